// File: rtl/imem_if.sv
// Load, fetch-request and fetch-response channels of the instruction memory responder.
// The master drives loads, requests and rsp_ready. The slave (the memory) drives the rest.
interface imem_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [7:0]  ld_byte;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_err;

    modport master (
        output ld_valid, ld_addr, ld_byte, req_valid, req_addr, rsp_ready,
        input  ld_ready, req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
    );

    modport slave (
        input  ld_valid, ld_addr, ld_byte, req_valid, req_addr, rsp_ready,
        output ld_ready, req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Byte-addressed instruction memory. It serves one fetch at a time and assembles the
// little-endian word one byte per cycle. Misaligned or out-of-range fetches get NOP_WORD with an error flag.
module imem_responder #(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic  clk,
    input  logic  rst_n,
    imem_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [7:0]     r_mem [DEPTH];
    logic [1:0]     r_beat;
    logic [31:0]    r_instr;
    logic [31:0]    r_pc;
    logic           r_err;

    logic           w_ld_fire;
    logic           w_ld_in_range;
    logic           w_req_fire;
    logic           w_req_good;
    logic           w_rsp_fire;
    logic [AW-1:0]  w_rd_idx;

    // 33-bit compares keep addresses near 2^32 from wrapping into range.
    assign w_ld_in_range = ({1'b0, bus.ld_addr} < 33'(DEPTH));
    assign w_req_good    = (bus.req_addr[1:0] == 2'b00) &&
                           (({1'b0, bus.req_addr} + 33'd3) < 33'(DEPTH));

    assign w_ld_fire  = bus.ld_valid  && bus.ld_ready;
    assign w_req_fire = bus.req_valid && bus.req_ready;
    assign w_rsp_fire = bus.rsp_valid && bus.rsp_ready;
    assign w_rd_idx   = r_pc[AW-1:0] + AW'(r_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_next = w_req_good ? READ : RESP;
                end
            end
            READ: begin
                if (r_beat == 2'd3) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (w_rsp_fire) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // A pending load takes priority, so a request waits while ld_valid is high.
    always_comb begin
        bus.ld_ready  = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.ld_ready  = 1'b1;
                bus.req_ready = !bus.ld_valid;
            end
            RESP:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= 2'd0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_req_fire) begin
            r_pc   <= bus.req_addr;
            r_beat <= 2'd0;
            if (w_req_good) begin
                r_instr <= 32'd0;
                r_err   <= 1'b0;
            end else begin
                r_instr <= NOP_WORD;
                r_err   <= 1'b1;
            end
        end else if (r_state == READ) begin
            r_instr[{r_beat, 3'b000} +: 8] <= r_mem[w_rd_idx];
            r_beat                         <= r_beat + 2'd1;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ld_fire && w_ld_in_range) begin
            r_mem[bus.ld_addr[AW-1:0]] <= bus.ld_byte;
        end
    end

    assign bus.rsp_instr = r_instr;
    assign bus.rsp_pc    = r_pc;
    assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed bench for imem_responder against a byte-array reference model.
module tb_imem_responder;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_if ifc ();

    imem_responder #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  m_mem [DEPTH];
    logic [31:0] words_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_good(input logic [31:0] pc);
        longint unsigned p = pc;
        return (pc[1:0] == 2'b00) && (p + 3 < DEPTH);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        int i;
        if (!is_good(pc)) return NOP;
        i = int'(pc);
        return {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
    endfunction

    task automatic load(input logic [31:0] addr, input logic [7:0] b);
        longint unsigned a = addr;
        @(negedge clk);
        ifc.ld_valid = 1'b1;
        ifc.ld_addr  = addr;
        ifc.ld_byte  = b;
        chk("ld_ready", 32'(ifc.ld_ready), 32'd1);
        @(posedge clk);
        #1;
        ifc.ld_valid = 1'b0;
        if (a < DEPTH) m_mem[int'(addr)] = b;
    endtask

    // Good fetch: rsp_valid is seen 4 edges after the accepting edge.
    // Error fetch: rsp_valid is seen right after the accepting edge, in the cycle that follows acceptance.
    task automatic fetch(input logic [31:0] pc, input int hold, input bit at_neg);
        logic [31:0] e_instr = exp_word(pc);
        logic        e_err   = !is_good(pc);
        int          e_lat   = e_err ? 0 : 4;
        int          n       = 0;
        int          lat     = 0;
        if (!at_neg) @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_addr  = pc;
        ifc.rsp_ready = (hold == 0);
        while (!ifc.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.req_ready) begin
            chk("req_accept_timeout", 32'd0, 32'd1);
            ifc.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        while (!ifc.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_latency", 32'(lat), 32'(e_lat));
        if (!ifc.rsp_valid) begin
            ifc.rsp_ready = 1'b1;
            return;
        end
        chk("rsp_instr", ifc.rsp_instr, e_instr);
        chk("rsp_pc", ifc.rsp_pc, pc);
        chk("rsp_err", 32'(ifc.rsp_err), 32'(e_err));
        chk("req_ready_busy", 32'(ifc.req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(ifc.rsp_valid), 32'd1);
            chk("hold_instr", ifc.rsp_instr, e_instr);
            chk("hold_pc", ifc.rsp_pc, pc);
            chk("hold_err", 32'(ifc.rsp_err), 32'(e_err));
            chk("hold_req_ready", 32'(ifc.req_ready), 32'd0);
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("done_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("done_req_ready", 32'(ifc.req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          seen;
        ifc.ld_valid  = 1'b0;
        ifc.ld_addr   = 32'd0;
        ifc.ld_byte   = 8'd0;
        ifc.req_valid = 1'b0;
        ifc.req_addr  = 32'd0;
        ifc.rsp_ready = 1'b1;

        #3;
        chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("rst_rsp_instr", ifc.rsp_instr, 32'd0);
        chk("rst_rsp_pc", ifc.rsp_pc, 32'd0);
        chk("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(ifc.req_ready), 32'd1);
        chk("post_rst_ld_ready", 32'(ifc.ld_ready), 32'd1);

        // Basic word and error cases
        load(32'd0, 8'h13);
        load(32'd1, 8'h05);
        load(32'd2, 8'h00);
        load(32'd3, 8'h00);
        words_q.push_back(32'd0);
        fetch(32'd0, 0, 0);
        chk("word0_model", exp_word(32'd0), 32'h00000513);
        fetch(32'd2, 0, 0);
        fetch(32'd1024, 0, 0);
        fetch(32'hFFFFFFFC, 0, 0);
        fetch(32'd1021, 0, 0);

        // Last in-range word
        load(32'd1020, 8'hA1);
        load(32'd1021, 8'hB2);
        load(32'd1022, 8'hC3);
        load(32'd1023, 8'hD4);
        words_q.push_back(32'd1020);
        fetch(32'd1020, 0, 0);

        // Out-of-range load must not alias onto low memory
        load(32'd1024, 8'hAA);
        load(32'd1025, 8'hBB);
        fetch(32'd0, 0, 0);

        fetch(32'd0, 5, 0);

        // A simultaneous load and request are handled load-first
        @(negedge clk);
        ifc.ld_valid  = 1'b1;
        ifc.ld_addr   = 32'd1;
        ifc.ld_byte   = 8'h06;
        ifc.req_valid = 1'b1;
        ifc.req_addr  = 32'd0;
        #1;
        chk("both_req_ready", 32'(ifc.req_ready), 32'd0);
        chk("both_ld_ready", 32'(ifc.ld_ready), 32'd1);
        @(posedge clk);
        #1;
        m_mem[1] = 8'h06;
        chk("both_stall_req_ready", 32'(ifc.req_ready), 32'd0);
        chk("both_stall_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        @(negedge clk);
        ifc.ld_valid = 1'b0;
        fetch(32'd0, 0, 1);
        chk("word0_new_model", exp_word(32'd0), 32'h00000613);

        // Asynchronous reset in the middle of a read
        load(32'd8, 8'h93);
        load(32'd9, 8'h80);
        load(32'd10, 8'h10);
        load(32'd11, 8'h00);
        words_q.push_back(32'd8);
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_addr  = 32'd8;
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midread_pc", ifc.rsp_pc, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("arst_rsp_instr", ifc.rsp_instr, 32'd0);
        chk("arst_rsp_pc", ifc.rsp_pc, 32'd0);
        chk("arst_rsp_err", 32'(ifc.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_req_ready", 32'(ifc.req_ready), 32'd1);
        chk("arst_ld_ready", 32'(ifc.ld_ready), 32'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ifc.rsp_valid) seen++;
        end
        chk("arst_no_response", 32'(seen), 32'd0);
        fetch(32'd8, 0, 0);

        // Randomized loads and fetches
        for (int it = 0; it < 40; it++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 4) begin
                logic [31:0] wa = 32'($urandom_range(0, DEPTH / 4 - 1)) * 32'd4;
                for (int b = 0; b < 4; b++) load(wa + 32'(b), 8'($urandom));
                words_q.push_back(wa);
            end
            r = int'($urandom_range(0, 9));
            if (r <= 5)      pc = words_q[$urandom_range(0, words_q.size() - 1)];
            else if (r == 6) pc = (32'($urandom_range(0, DEPTH - 1)) & ~32'd3) | 32'($urandom_range(1, 3));
            else if (r == 7) pc = 32'(DEPTH) + 32'($urandom_range(0, 4096));
            else if (r == 8) pc = 32'hFFFF0000 | 32'($urandom_range(0, 16'hFFFF));
            else             pc = 32'($urandom);
            if (is_good(pc)) begin
                bit known = 0;
                foreach (words_q[k]) if (words_q[k] == pc) known = 1;
                if (!known) pc = pc | 32'd1;
            end
            fetch(pc, int'($urandom_range(0, 3)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, byte capacity of the instruction memory (multiple of 4).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, word returned on an error response.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ld_valid  input  1  byte-load strobe.
REQ-006 SHALL have port ld_ready  output  1  byte load accepted this cycle when high with ld_valid.
REQ-007 SHALL have port ld_addr  input  32  byte address of the load.
REQ-008 SHALL have port ld_byte  input  8  byte data of the load.
REQ-009 SHALL have port req_valid  input  1  fetch request valid.
REQ-010 SHALL have port req_ready  output  1  fetch request accepted when high with req_valid.
REQ-011 SHALL have port req_addr  input  32  fetch PC (byte address).
REQ-012 SHALL have port rsp_valid  output  1  response valid.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL have port rsp_instr  output  32  fetched instruction word.
REQ-015 SHALL have port rsp_pc  output  32  PC of the request that produced this response.
REQ-016 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-017 SHALL hold a byte array of DEPTH entries; contents SHALL NOT be cleared by reset.
REQ-018 SHALL implement states IDLE, READ, RESP.
REQ-019 In IDLE: req_ready=1 and ld_ready=1. In READ and RESP: both SHALL be 0.
REQ-020 Load handshake (IDLE, ld_valid=1, ld_addr<DEPTH): SHALL write ld_byte to that byte; ld_addr>=DEPTH SHALL be accepted and dropped.
REQ-021 ld_valid and req_valid both high in IDLE: the load SHALL complete first; the request SHALL NOT be accepted that cycle (req_ready SHALL drop to 0 while ld_valid=1).
REQ-022 Accepted request with req_addr[1:0]==0 and req_addr+3<DEPTH: SHALL latch rsp_pc=req_addr and go IDLE->READ with beat counter 0.
REQ-023 READ SHALL capture one byte per cycle: at beat k (0..3), byte[pc+k] -> rsp_instr[8k+7:8k] (little-endian); after beat 3, READ->RESP.
REQ-024 Latency: rsp_valid SHALL rise exactly 4 cycles after the accepting edge for a good request.
REQ-025 Accepted request misaligned or with req_addr+3>=DEPTH (unsigned, no wrap; req_addr near 2^32 is out of range): SHALL go IDLE->RESP directly, rsp_valid 1 cycle after acceptance, rsp_instr=NOP_WORD, rsp_err=1, rsp_pc=req_addr.
REQ-026 In RESP rsp_valid=1; rsp_instr, rsp_pc, rsp_err SHALL be stable until rsp_valid&&rsp_ready.
REQ-027 On rsp_valid&&rsp_ready: SHALL return to IDLE next cycle; no back-to-back overlap (one request outstanding).
REQ-028 rsp_valid SHALL be 0 in IDLE and READ; rsp_err SHALL be 0 on every good response.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, beat counter 0, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0, independent of clk.
REQ-030 Reset asserted during READ or RESP SHALL abort the fetch with no response delivered; memory contents SHALL be retained.
REQ-031 After rst_n rises, req_ready and ld_ready SHALL be 1 from the first clock.

Verification
REQ-032 Load bytes 13,05,00,00 at 0..3; request pc=0, rsp_ready=1 -> rsp_valid 4 cycles after accept, rsp_instr=32'h00000513, rsp_pc=0, rsp_err=0.
REQ-033 Request pc=32'h2 -> rsp_valid next cycle, rsp_instr=32'h00000013, rsp_err=1, rsp_pc=2.
REQ-034 DEPTH=1024, request pc=1024 and pc=32'hFFFFFFFC -> both rsp_err=1, NOP_WORD, no memory access.
REQ-035 Good response with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_instr, rsp_pc held constant; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-036 ld_valid and req_valid high together in IDLE -> byte written, request stalled until ld_valid drops, then served with the new byte.
REQ-037 rst_n pulsed low mid-READ -> outputs zero asynchronously, no response; subsequent fetch of same pc returns preloaded word unchanged.
